// File: rtl/lcd_num_writer.sv
// HD44780 4-bit write-only driver: power-on init, then shows `value` as three ASCII digits on line 1.
// Build option LCD_ZERO_BLANK_EN: leading zero digits are written as spaces.
module lcd_num_writer #(
  parameter int unsigned T_PWR   = 750000,
  parameter int unsigned T_4MS   = 205000,
  parameter int unsigned T_100US = 5000,
  parameter int unsigned T_40US  = 2000,
  parameter int unsigned T_CLR   = 82000,
  parameter int unsigned T_E     = 12,
  parameter int unsigned T_NIB   = 50,
  parameter int unsigned COL     = 0
) (
  input  logic       clk,
  input  logic       rs_n,
  input  logic [7:0] value,
  output logic [3:0] lcd_d,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       sf_ce0,
  output logic       ready,
  output logic       busy
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAXP = max2(max2(max2(T_PWR, T_4MS), max2(T_100US, T_40US)),
                                      max2(max2(T_CLR, T_E), T_NIB));
  localparam int unsigned CW   = $clog2(MAXP + 1);

  typedef enum logic [2:0] {
    S_PWR_WAIT, S_INIT, S_IDLE, S_CONV, S_WR_ADDR, S_WR_D2, S_WR_D1, S_WR_D0
  } state_e;

  typedef enum logic [2:0] {TX_IDLE, TX_SETUP, TX_EHI, TX_HOLD, TX_GAP} tx_e;

  typedef struct packed {
    logic          rs;
    logic          nib;
    logic [7:0]    data;
    logic [CW-1:0] gap;
  } item_t;

  function automatic item_t init_item(input logic [2:0] s);
    item_t it;
    it = '0;
    unique case (s)
      3'd0:    begin it.nib = 1'b1; it.data = 8'h03; it.gap = CW'(T_4MS);   end
      3'd1:    begin it.nib = 1'b1; it.data = 8'h03; it.gap = CW'(T_100US); end
      3'd2:    begin it.nib = 1'b1; it.data = 8'h03; it.gap = CW'(T_40US);  end
      3'd3:    begin it.nib = 1'b1; it.data = 8'h02; it.gap = CW'(T_40US);  end
      3'd4:    begin it.data = 8'h28; it.gap = CW'(T_40US); end
      3'd5:    begin it.data = 8'h06; it.gap = CW'(T_40US); end
      3'd6:    begin it.data = 8'h0C; it.gap = CW'(T_40US); end
      default: begin it.data = 8'h01; it.gap = CW'(T_CLR);  end
    endcase
    return it;
  endfunction

  state_e        state_q, state_d;
  tx_e           tx_q, tx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [2:0]    step_q, step_d;
  logic [2:0]    dd_cnt_q, dd_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    shown_q, shown_d;
  logic [7:0]    bin_q, bin_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [3:0]    lcd_d_q, lcd_d_d;
  logic          lo_q, lo_d, nib_only_q, nib_only_d, rs_q, rs_d, e_q, e_d;
  logic          ready_q, ready_d, busy_q, busy_d, first_q, first_d;

  logic          tx_done, launch, conv_load, gap_last;
  logic [CW-1:0] gap_len;
  logic [11:0]   adj;
  logic [7:0]    ch_h, ch_t, ch_u;
  item_t         li;

  // Digit characters come from the finished conversion held in bcd_q.
  always_comb begin
    ch_u = 8'h30 | {4'h0, bcd_q[3:0]};
`ifdef LCD_ZERO_BLANK_EN
    ch_h = (bcd_q[11:8] == 4'd0) ? 8'h20 : (8'h30 | {4'h0, bcd_q[11:8]});
    ch_t = (bcd_q[11:4] == 8'd0) ? 8'h20 : (8'h30 | {4'h0, bcd_q[7:4]});
`else
    ch_h = 8'h30 | {4'h0, bcd_q[11:8]};
    ch_t = 8'h30 | {4'h0, bcd_q[7:4]};
`endif
  end

  always_comb begin
    adj = bcd_q;
    for (int unsigned k = 0; k < 3; k++) begin
      if (adj[k*4 +: 4] >= 4'd5) adj[k*4 +: 4] = adj[k*4 +: 4] + 4'd3;
    end
  end

  assign gap_len  = (nib_only_q || lo_q) ? gap_q : CW'(T_NIB);
  assign gap_last = (gap_len <= CW'(1)) || (cnt_q == gap_len - CW'(1));

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    step_d     = step_q;
    dd_cnt_d   = dd_cnt_q;
    byte_d     = byte_q;
    shown_d    = shown_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    lcd_d_d    = lcd_d_q;
    lo_d       = lo_q;
    nib_only_d = nib_only_q;
    rs_d       = rs_q;
    ready_d    = ready_q;
    first_d    = first_q;
    tx_done    = 1'b0;
    launch     = 1'b0;
    conv_load  = 1'b0;
    li         = '0;

    unique case (tx_q)
      TX_IDLE: ;
      TX_SETUP:
        if (cnt_q == CW'(1)) begin tx_d = TX_EHI; cnt_d = '0; end
        else cnt_d = cnt_q + 1'b1;
      TX_EHI:
        if (cnt_q == CW'(T_E - 1)) begin tx_d = TX_HOLD; cnt_d = '0; end
        else cnt_d = cnt_q + 1'b1;
      TX_HOLD: begin tx_d = TX_GAP; cnt_d = '0; end
      TX_GAP:
        if (gap_last) begin
          cnt_d = '0;
          if (nib_only_q || lo_q) begin
            tx_d    = TX_IDLE;
            tx_done = 1'b1;
          end else begin
            lo_d    = 1'b1;
            lcd_d_d = byte_q[3:0];
            tx_d    = TX_SETUP;
          end
        end else cnt_d = cnt_q + 1'b1;
      default: tx_d = TX_IDLE;
    endcase

    // Each write state launches its transfer on entry and advances on tx_done.
    unique case (state_q)
      S_PWR_WAIT:
        if (cnt_q == CW'(T_PWR - 1)) begin
          state_d = S_INIT;
          step_d  = '0;
          launch  = 1'b1;
          li      = init_item(3'd0);
        end else cnt_d = cnt_q + 1'b1;
      S_INIT:
        if (tx_done) begin
          if (step_q == 3'd7) begin
            ready_d   = 1'b1;
            state_d   = S_CONV;
            conv_load = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
            launch = 1'b1;
            li     = init_item(step_q + 3'd1);
          end
        end
      S_IDLE:
        if (first_q || (value != shown_q)) begin
          state_d   = S_CONV;
          conv_load = 1'b1;
        end
      S_CONV: begin
        bcd_d    = {adj[10:0], bin_q[7]};
        bin_d    = {bin_q[6:0], 1'b0};
        dd_cnt_d = dd_cnt_q + 3'd1;
        if (dd_cnt_q == 3'd7) begin
          state_d = S_WR_ADDR;
          launch  = 1'b1;
          li.data = 8'h80 | 8'(COL);
          li.gap  = CW'(T_40US);
        end
      end
      S_WR_ADDR:
        if (tx_done) begin
          state_d = S_WR_D2;
          launch  = 1'b1;
          li.rs   = 1'b1;
          li.data = ch_h;
          li.gap  = CW'(T_40US);
        end
      S_WR_D2:
        if (tx_done) begin
          state_d = S_WR_D1;
          launch  = 1'b1;
          li.rs   = 1'b1;
          li.data = ch_t;
          li.gap  = CW'(T_40US);
        end
      S_WR_D1:
        if (tx_done) begin
          state_d = S_WR_D0;
          launch  = 1'b1;
          li.rs   = 1'b1;
          li.data = ch_u;
          li.gap  = CW'(T_40US);
        end
      S_WR_D0:
        if (tx_done) state_d = S_IDLE;
      default: state_d = S_PWR_WAIT;
    endcase

    if (conv_load) begin
      shown_d  = value;
      bin_d    = value;
      bcd_d    = '0;
      dd_cnt_d = '0;
      first_d  = 1'b0;
    end

    if (launch) begin
      tx_d       = TX_SETUP;
      cnt_d      = '0;
      lo_d       = 1'b0;
      byte_d     = li.data;
      nib_only_d = li.nib;
      gap_d      = li.gap;
      rs_d       = li.rs;
      lcd_d_d    = li.nib ? li.data[3:0] : li.data[7:4];
    end

    busy_d = (state_d != S_IDLE);
    e_d    = (tx_d == TX_EHI);
  end

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      state_q    <= S_PWR_WAIT;
      tx_q       <= TX_IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      step_q     <= '0;
      dd_cnt_q   <= '0;
      byte_q     <= '0;
      shown_q    <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      lcd_d_q    <= '0;
      lo_q       <= 1'b0;
      nib_only_q <= 1'b0;
      rs_q       <= 1'b0;
      e_q        <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      step_q     <= step_d;
      dd_cnt_q   <= dd_cnt_d;
      byte_q     <= byte_d;
      shown_q    <= shown_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      lcd_d_q    <= lcd_d_d;
      lo_q       <= lo_d;
      nib_only_q <= nib_only_d;
      rs_q       <= rs_d;
      e_q        <= e_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      first_q    <= first_d;
    end
  end

  assign lcd_d  = lcd_d_q;
  assign lcd_e  = e_q;
  assign lcd_rs = rs_q;
  assign lcd_rw = 1'b0;
  assign sf_ce0 = 1'b1;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_lcd_num_writer.sv
// Bench for lcd_num_writer: bus decoder rebuilds nibbles/bytes on lcd_e fall and pops a scoreboard queue.
module tb_lcd_num_writer;

  localparam int unsigned P_TE = 3;
`ifdef LCD_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rs_n = 1'b0;
  logic [7:0] value = 8'd21;
  logic [3:0] lcd_d;
  logic       lcd_e, lcd_rs, lcd_rw, sf_ce0, ready, busy;

  lcd_num_writer #(
    .T_PWR(20), .T_4MS(10), .T_100US(5), .T_40US(4), .T_CLR(8),
    .T_E(P_TE), .T_NIB(2), .COL(0)
  ) dut (
    .clk(clk), .rs_n(rs_n), .value(value),
    .lcd_d(lcd_d), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .sf_ce0(sf_ce0), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_items = 0;
  logic [9:0] exp_q[$];  // {single_nibble, rs, byte}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dchar(input int d, input bit lead);
    if (BLANK && lead) return 8'h20;
    return 8'h30 + 8'(d);
  endfunction

  task automatic push_update(input logic [7:0] v);
    int h, t, u;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    u = int'(v) % 10;
    exp_q.push_back({2'b00, 8'h80});
    exp_q.push_back({2'b01, dchar(h, h == 0)});
    exp_q.push_back({2'b01, dchar(t, (h == 0) && (t == 0))});
    exp_q.push_back({2'b01, dchar(u, 1'b0)});
  endtask

  task automatic push_init(input logic [7:0] v);
    exp_q.push_back({2'b10, 8'h03});
    exp_q.push_back({2'b10, 8'h03});
    exp_q.push_back({2'b10, 8'h03});
    exp_q.push_back({2'b10, 8'h02});
    exp_q.push_back({2'b00, 8'h28});
    exp_q.push_back({2'b00, 8'h06});
    exp_q.push_back({2'b00, 8'h0C});
    exp_q.push_back({2'b00, 8'h01});
    push_update(v);
  endtask

  task automatic sb_item(input logic [9:0] item);
    n_items++;
    if (exp_q.size() == 0) check_eq("sb_unexpected", 32'(item), 32'h3FF);
    else check_eq("sb_item", 32'(item), 32'(exp_q.pop_front()));
  endtask

  // Bus decoder and strobe timing monitor, sampled on the falling clock edge.
  initial begin
    logic [4:0] cur, h1, h2, at_rise;
    logic       e1, e2, have_hi;
    logic [3:0] hi_nib;
    int         hi_cnt, nib_cnt;
    h1 = '0; h2 = '0; at_rise = '0; e1 = 1'b0; e2 = 1'b0;
    have_hi = 1'b0; hi_nib = '0; hi_cnt = 0; nib_cnt = 0;
    forever begin
      @(negedge clk);
      cur = {lcd_rs, lcd_d};
      if (!rs_n) begin
        nib_cnt = 0; have_hi = 1'b0; hi_cnt = 0;
      end else begin
        if (lcd_e && !e1) begin
          check_eq("setup", {28'd0, e2, e1, h1 != cur, h2 != cur}, 32'd0);
          at_rise = cur;
          hi_cnt  = 0;
        end
        if (lcd_e) hi_cnt++;
        if (!lcd_e && e1) begin
          check_eq("e_width", hi_cnt, P_TE);
          check_eq("hold", 32'(cur), 32'(at_rise));
          check_eq("rw_ce0", {30'd0, lcd_rw, sf_ce0}, 32'd1);
          if (nib_cnt < 4) sb_item({2'b10, 4'h0, cur[3:0]});
          else if (!have_hi) begin hi_nib = cur[3:0]; have_hi = 1'b1; end
          else begin sb_item({1'b0, cur[4], hi_nib, cur[3:0]}); have_hi = 1'b0; end
          nib_cnt++;
        end
      end
      e2 = e1; e1 = lcd_e; h2 = h1; h1 = cur;
    end
  end

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && ready && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check_eq({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_items(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (n_items < target && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) check_eq({tag, "_timeout"}, 32'(n_items), 32'(target));
  endtask

  task automatic wait_e_high(input int budget, input string tag);
    int n;
    n = 0;
    while (!lcd_e && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) check_eq({tag, "_timeout"}, 32'(lcd_e), 32'd1);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (40) @(negedge clk);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check_eq("rst_d", 32'(lcd_d), 32'd0);
    check_eq("rst_e", 32'(lcd_e), 32'd0);
    check_eq("rst_rs", 32'(lcd_rs), 32'd0);
    check_eq("rst_rw", 32'(lcd_rw), 32'd0);
    check_eq("rst_ce0", 32'(sf_ce0), 32'd1);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);

    push_init(8'd21);
    rs_n = 1'b1;
    @(negedge clk);
    check_eq("pwr_busy", 32'(busy), 32'd1);
    wait_drain(3000, "init");
    check_eq("init_ready", 32'(ready), 32'd1);
    check_eq("init_busy", 32'(busy), 32'd0);
    settle_and_check("idle21");

    value = 8'd255;
    push_update(8'd255);
    wait_drain(1000, "v255");
    settle_and_check("v255");

    value = 8'd8;
    push_update(8'd8);
    wait_drain(1000, "v8");
    settle_and_check("v8");

    value = 8'd0;
    push_update(8'd0);
    wait_drain(1000, "v0");
    settle_and_check("v0");

    // Change value twice while the tens digit is being written.
    base  = n_items;
    value = 8'd100;
    push_update(8'd100);
    wait_items(base + 2, 1000, "v100_d2");
    wait_e_high(200, "v100_d1");
    value = 8'd101;
    @(negedge clk);
    value = 8'd102;
    push_update(8'd102);
    wait_drain(2000, "v102");
    settle_and_check("v102");

    // Reset while the hundreds digit strobe is high.
    base  = n_items;
    value = 8'd55;
    push_update(8'd55);
    wait_items(base + 1, 1000, "v55_addr");
    wait_e_high(200, "v55_d2");
    @(posedge clk);
    #2 rs_n = 1'b0;
    #1;
    check_eq("mid_rst_e", 32'(lcd_e), 32'd0);
    check_eq("mid_rst_ready", 32'(ready), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd1);
    exp_q.delete();
    push_init(8'd55);
    repeat (2) @(posedge clk);
    #2 rs_n = 1'b1;
    wait_drain(3000, "reinit");
    check_eq("reinit_ready", 32'(ready), 32'd1);
    settle_and_check("reinit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
